// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator: H/V counters advanced by a pixel clock-enable,
// registered syncs, data-enable, coordinates, line/frame strobes and a look-ahead request stream.
module vga_timing_gen #(
  parameter int unsigned CNT_W      = 11,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned LEAD       = 2
) (
  input  logic             CLK,
  input  logic             SYNC_RST,
  input  logic             iPIX_EN,
  output logic             oH_SYNC,
  output logic             oV_SYNC,
  output logic             oDE,
  output logic [CNT_W-1:0] oCurrent_X,
  output logic [CNT_W-1:0] oCurrent_Y,
  output logic             oLINE_START,
  output logic             oFRAME_START,
  output logic             oREQ_VALID,
  output logic [CNT_W-1:0] oREQ_X,
  output logic [CNT_W-1:0] oREQ_Y
);

  localparam int unsigned BLANK_H = H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned TOTAL_H = BLANK_H + H_ACTIVE;
  localparam int unsigned BLANK_V = V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned TOTAL_V = BLANK_V + V_ACTIVE;
  localparam logic [CNT_W-1:0] HMax = CNT_W'(TOTAL_H - 1);
  localparam logic [CNT_W-1:0] VMax = CNT_W'(TOTAL_V - 1);

  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             ls_q, ls_d, fs_q, fs_d;
  logic             rv_q, rv_d;
  logic [CNT_W-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [31:0]      h_w, v_w;
  logic             v_act;

  // Compare in 32 bits so TOTAL_H == 2**CNT_W and h+LEAD cannot overflow.
  assign h_w   = 32'(hc_q);
  assign v_w   = 32'(vc_q);
  assign v_act = (v_w >= BLANK_V);

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == HMax) begin
      hc_d = '0;
      vc_d = (vc_q == VMax) ? '0 : vc_q + 1'b1;
    end

    hs_d = ((h_w >= H_FRONT) && (h_w < H_FRONT + H_SYNC)) ? H_SYNC_POL : ~H_SYNC_POL;
    vs_d = ((v_w >= V_FRONT) && (v_w < V_FRONT + V_SYNC)) ? V_SYNC_POL : ~V_SYNC_POL;

    de_d = (h_w >= BLANK_H) && v_act;
    x_d  = de_d  ? CNT_W'(h_w - BLANK_H) : '0;
    y_d  = v_act ? CNT_W'(v_w - BLANK_V) : '0;

    rv_d = (h_w + LEAD >= BLANK_H) && (h_w + LEAD < TOTAL_H) && v_act;
    rx_d = rv_d ? CNT_W'(h_w + LEAD - BLANK_H) : '0;
    ry_d = rv_d ? CNT_W'(v_w - BLANK_V) : '0;

    ls_d = iPIX_EN && (hc_q == '0);
    fs_d = ls_d && (vc_q == '0);
  end

  always_ff @(posedge CLK or posedge SYNC_RST) begin
    if (SYNC_RST) begin
      hc_q <= '0;
      vc_q <= '0;
      hs_q <= ~H_SYNC_POL;
      vs_q <= ~V_SYNC_POL;
      de_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      rv_q <= 1'b0;
      rx_q <= '0;
      ry_q <= '0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      // Strobes are recomputed every cycle so they never stretch across idle cycles.
      ls_q <= ls_d;
      fs_q <= fs_d;
      if (iPIX_EN) begin
        hc_q <= hc_d;
        vc_q <= vc_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        x_q  <= x_d;
        y_q  <= y_d;
        rv_q <= rv_d;
        rx_q <= rx_d;
        ry_q <= ry_d;
      end
    end
  end

  assign oH_SYNC      = hs_q;
  assign oV_SYNC      = vs_q;
  assign oDE          = de_q;
  assign oCurrent_X   = x_q;
  assign oCurrent_Y   = y_q;
  assign oLINE_START  = ls_q;
  assign oFRAME_START = fs_q;
  assign oREQ_VALID   = rv_q;
  assign oREQ_X       = rx_q;
  assign oREQ_Y       = ry_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (TOTAL_H = 2**CNT_W) against a tick-count model.
module tb_vga_timing_gen;

  localparam int W    = 5;
  localparam int HF   = 3;
  localparam int HS   = 4;
  localparam int HB   = 5;
  localparam int HA   = 20;
  localparam int VF   = 2;
  localparam int VS   = 2;
  localparam int VB   = 3;
  localparam int VA   = 4;
  localparam int LEAD = 2;
  localparam bit HPOL = 1'b1;
  localparam bit VPOL = 1'b0;
  localparam int BH   = HF + HS + HB;
  localparam int TH   = BH + HA;
  localparam int BV   = VF + VS + VB;
  localparam int TV   = BV + VA;
  localparam int VW   = 6 + 4 * W;

  logic         CLK;
  logic         SYNC_RST;
  logic         iPIX_EN;
  logic         oH_SYNC, oV_SYNC, oDE, oLINE_START, oFRAME_START, oREQ_VALID;
  logic [W-1:0] oCurrent_X, oCurrent_Y, oREQ_X, oREQ_Y;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: outputs are a function of how many ticks have happened since reset.
  int           ticks;
  logic         e_hs, e_vs, e_de, e_ls, e_fs, e_rv;
  logic [W-1:0] e_x, e_y, e_rx, e_ry;

  vga_timing_gen #(
    .CNT_W(W), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL), .LEAD(LEAD)
  ) dut (
    .CLK(CLK), .SYNC_RST(SYNC_RST), .iPIX_EN(iPIX_EN),
    .oH_SYNC(oH_SYNC), .oV_SYNC(oV_SYNC), .oDE(oDE),
    .oCurrent_X(oCurrent_X), .oCurrent_Y(oCurrent_Y),
    .oLINE_START(oLINE_START), .oFRAME_START(oFRAME_START),
    .oREQ_VALID(oREQ_VALID), .oREQ_X(oREQ_X), .oREQ_Y(oREQ_Y)
  );

  always #5 CLK = ~CLK;

  function automatic logic [VW-1:0] act_vec();
    return {oH_SYNC, oV_SYNC, oDE, oCurrent_X, oCurrent_Y, oLINE_START, oFRAME_START,
            oREQ_VALID, oREQ_X, oREQ_Y};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_hs, e_vs, e_de, e_x, e_y, e_ls, e_fs, e_rv, e_rx, e_ry};
  endfunction

  task automatic model_reset();
    ticks = 0;
    e_hs = ~HPOL; e_vs = ~VPOL; e_de = 1'b0; e_ls = 1'b0; e_fs = 1'b0; e_rv = 1'b0;
    e_x = '0; e_y = '0; e_rx = '0; e_ry = '0;
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, settle.
  task automatic clk_step();
    int h, v;
    @(posedge CLK);
    if (SYNC_RST) begin
      model_reset();
    end else if (iPIX_EN) begin
      h = ticks % TH;
      v = (ticks / TH) % TV;
      e_hs = (h >= HF && h < HF + HS) ? HPOL : ~HPOL;
      e_vs = (v >= VF && v < VF + VS) ? VPOL : ~VPOL;
      e_de = (h >= BH) && (v >= BV);
      e_x  = e_de ? W'(h - BH) : '0;
      e_y  = (v >= BV) ? W'(v - BV) : '0;
      e_rv = (h >= BH - LEAD) && (h < TH - LEAD) && (v >= BV);
      e_rx = e_rv ? W'(h + LEAD - BH) : '0;
      e_ry = e_rv ? W'(v - BV) : '0;
      e_ls = (h == 0);
      e_fs = (h == 0) && (v == 0);
      ticks++;
    end else begin
      e_ls = 1'b0;
      e_fs = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    SYNC_RST = 1'b1;
    iPIX_EN  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h expected %h", act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (oH_SYNC !== ~HPOL) begin
      n_fail++;
      $display("FAIL reset_hsync_idle: got %b expected %b", oH_SYNC, ~HPOL);
    end
  endtask

  task automatic test_continuous();
    int de_cnt = 0, hs_cnt = 0, ls_cnt = 0, fs_cnt = 0;
    SYNC_RST = 1'b0;
    iPIX_EN  = 1'b1;
    for (int i = 0; i < TH * TV; i++) begin
      clk_step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL continuous cyc %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      de_cnt += int'(oDE);
      hs_cnt += int'(oH_SYNC == HPOL);
      ls_cnt += int'(oLINE_START);
      fs_cnt += int'(oFRAME_START);
    end
    n_checks++;
    if (de_cnt != HA * VA) begin
      n_fail++;
      $display("FAIL de_per_frame: got %0d expected %0d", de_cnt, HA * VA);
    end
    n_checks++;
    if (hs_cnt != HS * TV) begin
      n_fail++;
      $display("FAIL hsync_active_per_frame: got %0d expected %0d", hs_cnt, HS * TV);
    end
    n_checks++;
    if (ls_cnt != TV || fs_cnt != 1) begin
      n_fail++;
      $display("FAIL strobes_per_frame: got %0d/%0d expected %0d/1", ls_cnt, fs_cnt, TV);
    end
  endtask

  task automatic test_half_rate();
    int last_ls = -1;
    for (int i = 0; i < 2 * TH * 3; i++) begin
      iPIX_EN = i[0];
      clk_step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL half_rate cyc %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
      if (oLINE_START) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (i - last_ls != 2 * TH) begin
            n_fail++;
            $display("FAIL half_rate_line_period: got %0d expected %0d", i - last_ls, 2 * TH);
          end
        end
        last_ls = i;
      end
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      iPIX_EN = ($urandom % 3) != 0;
      clk_step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_en cyc %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_midframe_reset();
    int guard = 0;
    iPIX_EN = 1'b1;
    while (!((ticks % TH) == 25 && ((ticks / TH) % TV) == 7) && guard < 2 * TH * TV) begin
      clk_step();
      guard++;
    end
    n_checks++;
    if (guard >= 2 * TH * TV) begin
      n_fail++;
      $display("FAIL midframe_reach: got %0d steps expected < %0d", guard, 2 * TH * TV);
    end
    clk_step();
    n_checks++;
    if (oDE !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_active: got %b expected 1", oDE);
    end
    // Assert reset between edges; outputs must drop without a clock.
    #2;
    SYNC_RST = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", act_vec(), exp_vec());
    end
    clk_step();
    clk_step();
    SYNC_RST = 1'b0;
    iPIX_EN  = 1'b0;
    clk_step();
    n_checks++;
    if (oLINE_START !== 1'b0 || oFRAME_START !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b%b expected 00", oLINE_START, oFRAME_START);
    end
    iPIX_EN = 1'b1;
    clk_step();
    n_checks++;
    if (oLINE_START !== 1'b1 || oFRAME_START !== 1'b1) begin
      n_fail++;
      $display("FAIL first_tick_strobes: got %b%b expected 11", oLINE_START, oFRAME_START);
    end
    for (int i = 0; i < TH * 2; i++) begin
      clk_step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset cyc %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    CLK      = 1'b0;
    SYNC_RST = 1'b1;
    iPIX_EN  = 1'b0;
    model_reset();
    test_reset();
    test_continuous();
    test_half_rate();
    test_random_enable();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
